// File: rtl/arb_pkg.sv
// Shared constants, state encoding and pointer helper for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
        return SEL_W'((int'(sel) + 1) % NUM_REQ);
    endfunction

endpackage

// File: rtl/rr_arbiter8_mux8.sv
// Plain 8:1 data selector; the arbiter drives it with the registered grant index.
module mux8
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [SEL_W-1:0] signal,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = d0;
        case (signal)
            3'd1:    out = d1;
            3'd2:    out = d2;
            3'd3:    out = d3;
            3'd4:    out = d4;
            3'd5:    out = d5;
            3'd6:    out = d6;
            3'd7:    out = d7;
            default: out = d0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one valid/ready beat port between 8 requesters.
// A grant lasts until the grantee's last beat or until MAX_BEATS beats have moved.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         grant_sel,
    output logic                     grant_active
);

    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    arb_state_e       state_reg, state_next;
    logic [SEL_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic [WIDTH-1:0] slice [NUM_REQ];
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] scan_idx;
    logic             pick_found;
    logic             busy;
    logic             xfer;
    logic             rel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign slice[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    mux8 #(.WIDTH(WIDTH)) u_mux (
        .d0     (slice[0]),
        .d1     (slice[1]),
        .d2     (slice[2]),
        .d3     (slice[3]),
        .d4     (slice[4]),
        .d5     (slice[5]),
        .d6     (slice[6]),
        .d7     (slice[7]),
        .signal (sel_reg),
        .out    (out_data)
    );

    // Rotating priority: first requester found scanning upward from rr_ptr, wrapping mod 8.
    always_comb begin
        pick       = rr_ptr_reg;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr_reg + SEL_W'(k);
            if (!pick_found && req_valid[scan_idx]) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
        end
    end

    // Outputs decode from state alone so an asserted reset clears them without a clock.
    assign busy         = (state_reg == BUSY);
    assign grant_active = busy;
    assign grant_sel    = sel_reg;
    assign out_valid    = busy & req_valid[sel_reg];
    assign out_last     = busy & req_last[sel_reg];
    assign req_ready    = (busy && out_ready) ? (NUM_REQ'(1) << sel_reg) : '0;

    assign xfer = out_valid & out_ready;
    assign rel  = xfer & (out_last | (beat_cnt_reg == CNT_LAST));

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        sel_next      = sel_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    sel_next      = pick;
                    beat_cnt_next = '0;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                end
                if (rel) begin
                    rr_ptr_next = next_ptr(sel_reg);
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            sel_reg      <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            sel_reg      <= sel_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: per-requester beat queues drive the DUT, a tenure-level
// round-robin model predicts every output each cycle.
module tb_rr_arbiter8;

    localparam int W    = 32;
    localparam int MAXB = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    req_valid;
    logic [7:0]    req_last;
    logic [8*W-1:0] req_data;
    logic [7:0]    req_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_ready;
    logic [2:0]    grant_sel;
    logic          grant_active;

    rr_arbiter8 #(.WIDTH(W), .MAX_BEATS(MAXB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .grant_sel    (grant_sel),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Beat queues per requester: data and last flag, consumed from head.
    logic [W-1:0] dmem [8][DEPTH];
    bit           lmem [8][DEPTH];
    int           head [8];
    int           tail [8];

    // Reference model: owner<0 means no grant; sel is the last granted index.
    int m_owner, m_ptr, m_sel, m_cnt, cyc;
    int grant_q[$], grant_cyc_q[$], ten_cnt_q[$];
    bit ten_last_q[$];
    bit ready_q[$];
    int dut_xfers;
    bit rand_gate, rand_ready, rand_fill;

    task automatic push_beat(input int r, input logic [W-1:0] d, input bit l);
        if (head[r] == tail[r]) begin
            head[r] = 0;
            tail[r] = 0;
        end
        dmem[r][tail[r]] = d;
        lmem[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic push_burst(input int r, input int n);
        for (int b = 0; b < n; b++)
            push_beat(r, {4'(r), 28'($urandom)}, (b == n - 1));
    endtask

    function automatic bit all_idle();
        for (int r = 0; r < 8; r++)
            if (head[r] != tail[r]) return 1'b0;
        return (m_owner < 0);
    endfunction

    task automatic clear_logs();
        grant_q.delete();
        grant_cyc_q.delete();
        ten_cnt_q.delete();
        ten_last_q.delete();
        dut_xfers = 0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        m_cnt   = 0;
        for (int r = 0; r < 8; r++) begin
            head[r] = 0;
            tail[r] = 0;
        end
    endtask

    task automatic step();
        logic [7:0]   v, l;
        logic [W-1:0] drv_d [8];
        bit           r, act, has, g;
        @(negedge clk);
        if (rand_fill)
            for (int q = 0; q < 8; q++)
                if (head[q] == tail[q] && $urandom_range(0, 5) == 0)
                    push_burst(q, $urandom_range(1, 6));
        for (int q = 0; q < 8; q++) begin
            has = (head[q] < tail[q]);
            g   = rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
            v[q] = has && g;
            drv_d[q] = has ? dmem[q][head[q]] : W'($urandom);
            l[q] = has ? lmem[q][head[q]] : 1'($urandom_range(0, 1));
            req_data[q*W +: W] = drv_d[q];
        end
        req_valid = v;
        req_last  = l;
        if (ready_q.size() > 0) r = ready_q.pop_front();
        else r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = r;
        #1;
        act = (m_owner >= 0);
        check_val("grant_active", 64'(grant_active), 64'(act));
        check_val("grant_sel", 64'(grant_sel), 64'(m_sel));
        check_val("out_data", 64'(out_data), 64'(drv_d[m_sel]));
        check_val("out_valid", 64'(out_valid), 64'(act && v[m_sel]));
        check_val("out_last", 64'(out_last), 64'(act && l[m_sel]));
        check_val("req_ready", 64'(req_ready), (act && r) ? 64'(1) << m_sel : 64'(0));
        if (out_valid && out_ready) dut_xfers++;
        if (m_owner < 0) begin
            if (v != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (v[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                        break;
                    end
                end
                m_sel = m_owner;
                m_cnt = 0;
                grant_q.push_back(m_owner);
                grant_cyc_q.push_back(cyc);
            end
        end else if (v[m_owner] && r) begin
            head[m_owner]++;
            m_cnt++;
            if (l[m_owner] || m_cnt == MAXB) begin
                ten_cnt_q.push_back(m_cnt);
                ten_last_q.push_back(l[m_owner]);
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end
        end
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (!all_idle() && k < budget) begin
            step();
            k++;
        end
        check_val(tag, 64'(all_idle()), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_g [6] = '{2, 5, 2, 5, 2, 5};
        int exp_n [6] = '{4, 4, 4, 4, 2, 2};
        bit exp_l [6] = '{0, 0, 0, 0, 1, 1};
        logic [W-1:0] s0;
        rand_gate = 0; rand_ready = 0; rand_fill = 0;
        cyc = 0;
        model_reset();
        clear_logs();
        rst_n = 1'b0;
        req_valid = 8'h00; req_last = 8'h00; req_data = '0; out_ready = 1'b1;

        // Reset held with every requester asking.
        repeat (3) @(negedge clk);
        req_valid = 8'hFF;
        for (int q = 0; q < 8; q++) req_data[q*W +: W] = W'($urandom);
        s0 = req_data[W-1:0];
        #1;
        check_val("rst_grant_active", 64'(grant_active), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_last", 64'(out_last), 64'd0);
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        check_val("rst_grant_sel", 64'(grant_sel), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'(s0));
        @(negedge clk);
        req_valid = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");

        // Fairness: requester 0 has two single-beat transactions, others one.
        clear_logs();
        push_burst(0, 1);
        for (int q = 0; q < 8; q++) push_burst(q, 1);
        drain("fair_drain", 60);
        for (int i = 0; i < 9; i++) begin
            check_val("fair_order", 64'(i < grant_q.size() ? grant_q[i] : -1), 64'(i % 8));
            $display("fair grant %0d -> %0d", i, i < grant_q.size() ? grant_q[i] : -1);
        end
        for (int i = 1; i < 9; i++)
            check_val("fair_tenure_len",
                      64'(i < grant_cyc_q.size() ? grant_cyc_q[i] - grant_cyc_q[i-1] : -1), 64'd2);

        // Single two-beat burst from requester 3.
        clear_logs();
        push_beat(3, 32'hA, 1'b0);
        push_beat(3, 32'hB, 1'b1);
        drain("single_drain", 20);
        check_val("single_grant", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd3);
        check_val("single_beats", 64'(dut_xfers), 64'd2);
        $display("single burst: grant=3 beats=%0d", dut_xfers);

        // Pointer now 4: requester 5 must beat requester 0.
        clear_logs();
        push_burst(0, 1);
        push_burst(5, 1);
        drain("ptr_drain", 20);
        check_val("ptr_first", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd5);
        check_val("ptr_second", 64'(grant_q.size() > 1 ? grant_q[1] : -1), 64'd0);

        // Backpressure: four dead cycles after the first beat.
        clear_logs();
        push_burst(1, 4);
        for (int i = 0; i < 10; i++) ready_q.push_back(!(i >= 2 && i < 6));
        drain("bp_drain", 30);
        check_val("bp_grant", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd1);
        check_val("bp_beats", 64'(dut_xfers), 64'd4);
        check_val("bp_last", 64'(ten_last_q.size() > 0 ? ten_last_q[0] : 0), 64'd1);
        $display("backpressure: beats=%0d", dut_xfers);

        // Forced release: two 10-beat bursts with MAX_BEATS=4.
        clear_logs();
        push_burst(2, 10);
        push_burst(5, 10);
        drain("forced_drain", 80);
        for (int i = 0; i < 6; i++) begin
            check_val("forced_grant", 64'(i < grant_q.size() ? grant_q[i] : -1), 64'(exp_g[i]));
            check_val("forced_beats", 64'(i < ten_cnt_q.size() ? ten_cnt_q[i] : -1), 64'(exp_n[i]));
            check_val("forced_last", 64'(i < ten_last_q.size() ? ten_last_q[i] : 1'bx), 64'(exp_l[i]));
            $display("forced tenure %0d: grant=%0d beats=%0d", i,
                     i < grant_q.size() ? grant_q[i] : -1, i < ten_cnt_q.size() ? ten_cnt_q[i] : -1);
        end

        // Random traffic with valid gaps and random backpressure.
        clear_logs();
        rand_gate = 1; rand_ready = 1; rand_fill = 1;
        repeat (1500) step();
        rand_fill = 0; rand_gate = 0; rand_ready = 0;
        drain("rand_drain", 300);
        check_val("rand_activity", 64'(grant_q.size() > 50), 64'd1);
        $display("random phase: grants=%0d beats=%0d", grant_q.size(), dut_xfers);

        // Asynchronous reset in the middle of a requester 6 tenure.
        clear_logs();
        push_burst(6, 4);
        for (int k = 0; k < 20 && !(m_owner == 6 && m_cnt == 2); k++) step();
        check_val("arst_setup_owner", 64'(grant_sel), 64'd6);
        check_val("arst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_grant_active", 64'(grant_active), 64'd0);
        check_val("arst_req_ready", 64'(req_ready), 64'd0);
        check_val("arst_grant_sel", 64'(grant_sel), 64'd0);
        model_reset();
        req_valid = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        push_burst(6, 2);
        push_burst(1, 2);
        drain("arst_drain", 30);
        check_val("arst_first", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd1);
        check_val("arst_second", 64'(grant_q.size() > 1 ? grant_q[1] : -1), 64'd6);
        $display("post reset grants: %0d then %0d",
                 grant_q.size() > 0 ? grant_q[0] : -1, grant_q.size() > 1 ? grant_q[1] : -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream WIDTH-bit valid/ready port between 8 upstream requesters.
- The data path is a single 8:1 select, driven by the registered grant index.
- A grant is held for the whole transaction (until the requester's last beat) or until a beat limit forces release.
- Sits between bus masters (fetch, LSU, DMA, debug, ...) and a single-ported memory or peripheral interface.

Parameters:
- WIDTH, 32, data bits per beat.
- MAX_BEATS, 16, maximum beats per tenure before forced release; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  8  per-requester beat valid.
- req_last  input  8  per-requester last-beat flag; qualified by req_valid.
- req_data  input  8*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- req_ready  output  8  per-requester beat accepted.
- out_valid  output  1  downstream beat valid.
- out_data  output  WIDTH  downstream beat data.
- out_last  output  1  downstream last flag.
- out_ready  input  1  downstream accept.
- grant_sel  output  3  registered index of the current grantee.
- grant_active  output  1  high while in BUSY.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, grant_sel=0, beat_cnt=0.
  - Outputs during reset: grant_active=0, out_valid=0, out_last=0, req_ready=8'h00.
  - out_data follows the mux select, so it shows req_data slice 0 during reset.
- State IDLE:
  - out_valid=0, req_ready=0.
  - If |req_valid, select the first set bit scanning rr_ptr, rr_ptr+1, ... mod 8.
  - Register that index into grant_sel, clear beat_cnt, go to BUSY.
  - If no requests, stay in IDLE.
- State BUSY:
  - out_valid = req_valid[grant_sel]
  - out_data = req_data slice grant_sel
  - out_last = req_last[grant_sel]
  - req_ready = (8'b1 << grant_sel) when out_ready, else 8'h00
- A beat transfers when out_valid && out_ready; beat_cnt increments on each transfer.
- Release occurs on a transferred beat if out_last=1 or beat_cnt==MAX_BEATS-1.
  - On release: rr_ptr = (grant_sel+1) mod 8, next state = IDLE.
  - Forced release does not alter out_last; the requester continues its burst on its next grant.
- Latency: a request arriving in IDLE yields earliest out_valid on the next cycle.
  - Every tenure costs a 1-cycle arbitration bubble; no back-to-back grant.
- Grantee drops req_valid mid-tenure: the grant is held, out_valid=0, beat_cnt is frozen, and there is no timeout.
- Backpressure (out_ready=0): out_data tracks the grantee's inputs, req_ready=0, state and beat_cnt are unchanged.
- Requests arriving in BUSY are ignored until the next IDLE arbitration.
- rr_ptr wraps 7 -> 0.
- Reset asserted mid-burst: outputs return to reset values immediately (combinationally via state).
  - The in-flight burst is abandoned and arbitration restarts with rr_ptr=0.
- MAX_BEATS=1 gives single-beat round-robin.
- beat_cnt width is $clog2(MAX_BEATS), minimum 1 bit.

Decomposition:
- Package arb_pkg holds:
  - NUM_REQ=8 and SEL_W=3.
  - The state enum (IDLE, BUSY) as logic [0:0].
  - The next-pointer function ((sel+1) mod NUM_REQ).
- One sub-module, mux8 (WIDTH passed through):
  - d0..d7 are the req_data slices, signal=grant_sel, out feeds out_data.
  - last/valid selection is done by bit-indexing in the top.
- The rotating priority encoder is an always_comb block in the top; it is not a separate module.

Test Plan:
- Reset: hold rst_n=0 with req_valid=8'hFF -> grant_active=0, out_valid=0, req_ready=8'h00. First grant after release is grant_sel=0.
- Single burst: requester 3 sends beats 32'hA, then 32'hB with last, out_ready=1.
  - Grant one cycle later with grant_sel=3.
  - out_data A then B, req_ready=8'h08 on both beats.
  - IDLE next, rr_ptr=4.
- Fairness: all 8 requesters hold valid with single-beat last and out_ready=1 -> grant order 0,1,2,...,7,0, each tenure exactly 2 cycles.
- Backpressure: mid-burst, out_ready=0 for 4 cycles -> req_ready=8'h00, beat_cnt frozen, no beat lost or duplicated once out_ready=1.
- Forced release: MAX_BEATS=4, requesters 2 and 5 each stream 10 beats -> grants alternate 2(4 beats), 5(4), 2(4), 5(4), 2(2), 5(2), with no out_last on forced releases.
- Async reset mid-burst: assert rst_n=0 between clock edges during a requester 6 tenure -> out_valid and grant_active fall without a clock edge. After release, requester 6 and requester 1 both valid -> grant_sel=1 first.
